seg7_digit_sequencer: RTL and testbench
=======================================

// Module: seg7_digit_sequencer
// PURPOSE
//  Sequencer for the single-digit 7-segment counter display on a TinyTapeout tile.
//  Replaces the free-running ripple-counter display with one synchronous controller.
//  Features: run/hold control, up/down direction, single-step, selectable prescaler.
//  Drives segments a..g plus the decimal point, which flags a wrap-around.
// PARAMETERS
//  PRESCALE_W   8  free-running prescaler width; must be >= 7
//  SYNC_STAGES  2  synchronizer flops on run/dir/step pins; must be >= 2
// PORTS
//  io_in[0]    input   1  clk; all state updates on its rising edge
//  io_in[1]    input   1  reset; synchronous, active-high
//  io_in[2]    input   1  run: 1 = auto-advance, 0 = hold
//  io_in[3]    input   1  dir: 0 = count up, 1 = count down
//  io_in[4]    input   1  step: a rising edge advances one digit, honoured only in IDLE
//  io_in[7:5]  input   3  sel: tick period = 2^sel clk cycles (sel=0: every cycle)
//  io_out[6:0] output  7  segments g..a (bit0=a), active-high
//  io_out[7]   output  1  dp: one-cycle pulse on the cycle the digit wraps
// BEHAVIOUR
//  - Reset (io_in[1]=1 at a rising edge), with priority over everything else:
//    digit=0; state=IDLE; prescaler=0; sync and step-edge flops=0.
//    Resulting outputs: io_out[6:0]=0x3F, dp=0.
//  - run/dir/step pass through SYNC_STAGES flops. The FSM sees only the synced versions.
//  - step_pulse = synced step AND NOT its previous synced value.
//  - FSM states:
//    IDLE -> RUN when run_s=1.
//      In IDLE the prescaler is held at 0.
//      step_pulse advances the digit once.
//    RUN -> IDLE when run_s=0, on the next edge.
//      The digit is held at its current value.
//      The prescaler clears to 0.
//      step_pulse is ignored in RUN.
//  - Prescaler:
//    Increments every cycle in RUN and wraps modulo 2^PRESCALE_W.
//    mask = (1<<sel)-1. tick = RUN && ((pre & mask) == mask).
//    The first tick comes 2^sel cycles after RUN entry.
//  - Advance, on a tick or an accepted step_pulse:
//    Up: digit = (digit==MAX) ? 0 : digit+1.
//    Down: digit = (digit==0) ? MAX : digit-1.
//    MAX = 9 by default.
//  - dp is registered and is 1 only for the cycle after a wrapping advance.
//  - dir and sel are sampled at each advance. A change mid-run affects the next advance only.
//    Changing sel does not clear the prescaler.
//  - Segment decode is combinational from the registered digit, so io_out changes on the
//    same edge as digit. Encodings:
//    0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
//  - Pin-to-display latency for step: SYNC_STAGES+2 edges (sync, edge flop, digit register).
//  - Reset mid-RUN: the next edge forces the reset values. No partial advance occurs.
// CONFIGURATION
//  SEG7_SEQ_HEX_EN defined:
//    MAX = 15, with extra encodings A=77 b=7C C=39 d=5E E=79 F=71.
//    Wrap points are F->0 (up) and 0->F (down).
//  SEG7_SEQ_HEX_EN undefined: decimal only, MAX=9.
//    Digit values 10-15 are unreachable. Their decode is 0x00 (blank).
// TESTING
//  1. Reset held 2 cycles with run=0 -> io_out=0x3F, dp=0, state IDLE.
//  2. dir=0, run=0, three step pulses each 4 cycles wide -> io_out=0x4F (digit 3), dp never 1.
//  3. From digit 0, dir=1, one step -> io_out=0x6F (9) and dp=1 for exactly one cycle
//     (hex build: 0x71, F).
//  4. run=1, sel=0 -> digit advances every cycle after sync latency.
//     sel=3 -> advances every 8 cycles; step pulses have no effect.
//  5. run=1 then run=0 mid-count -> digit frozen; prescaler=0.
//     Re-run with sel=2 -> first advance 4 cycles after RUN entry.
//  6. Reset asserted while RUN, sel=0 -> next edge io_out=0x3F, dp=0, state IDLE.

Source files
------------

// File: rtl/seg7_digit_sequencer.sv
// Synchronous single-digit 7-segment sequencer: run/hold, up/down, single-step, 2^sel prescaler.
// Define SEG7_SEQ_HEX_EN for hexadecimal counting (0-F); otherwise the digit counts 0-9.
module seg7_digit_sequencer #(
  parameter int PRESCALE_W  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

`ifdef SEG7_SEQ_HEX_EN
  localparam logic [3:0] MAX = 4'd15;
`else
  localparam logic [3:0] MAX = 4'd9;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic clk;
  logic reset;
  logic [2:0] sel;

  assign clk   = io_in[0];
  assign reset = io_in[1];
  assign sel   = io_in[7:5];

  logic [SYNC_STAGES-1:0] runSync_q;
  logic [SYNC_STAGES-1:0] dirSync_q;
  logic [SYNC_STAGES-1:0] stepSync_q;
  logic                   stepPrev_q;
  logic                   stepPulse_q;
  state_t                 state_q, state_d;
  logic [PRESCALE_W-1:0]  pre_q, pre_d;
  logic [3:0]             digit_q, digit_d;
  logic                   dp_q, dp_d;

  logic                  runS;
  logic                  dirS;
  logic                  stepS;
  logic [PRESCALE_W-1:0] mask;
  logic                  tick;
  logic                  advance;
  logic [6:0]            seg;

  assign runS  = runSync_q[SYNC_STAGES-1];
  assign dirS  = dirSync_q[SYNC_STAGES-1];
  assign stepS = stepSync_q[SYNC_STAGES-1];

  // When sel reaches PRESCALE_W the shift overflows to zero and the mask becomes all ones.
  assign mask = (PRESCALE_W'(1) << sel) - PRESCALE_W'(1);
  assign tick = (state_q == RUN) && ((pre_q & mask) == mask);

  always_ff @(posedge clk) begin
    if (reset) begin
      runSync_q   <= '0;
      dirSync_q   <= '0;
      stepSync_q  <= '0;
      stepPrev_q  <= 1'b0;
      stepPulse_q <= 1'b0;
      state_q     <= IDLE;
      pre_q       <= '0;
      digit_q     <= 4'd0;
      dp_q        <= 1'b0;
    end else begin
      runSync_q   <= {runSync_q[SYNC_STAGES-2:0], io_in[2]};
      dirSync_q   <= {dirSync_q[SYNC_STAGES-2:0], io_in[3]};
      stepSync_q  <= {stepSync_q[SYNC_STAGES-2:0], io_in[4]};
      stepPrev_q  <= stepS;
      stepPulse_q <= stepS & ~stepPrev_q;
      state_q     <= state_d;
      pre_q       <= pre_d;
      digit_q     <= digit_d;
      dp_q        <= dp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    digit_d = digit_q;
    dp_d    = 1'b0;
    advance = 1'b0;

    unique case (state_q)
      IDLE: begin
        pre_d   = '0;
        advance = stepPulse_q;
        if (runS) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Dropping run freezes the digit even if a tick lines up on the same cycle.
        if (!runS) begin
          state_d = IDLE;
          pre_d   = '0;
        end else begin
          pre_d   = pre_q + PRESCALE_W'(1);
          advance = tick;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (advance) begin
      if (dirS) begin
        if (digit_q == 4'd0) begin
          digit_d = MAX;
          dp_d    = 1'b1;
        end else begin
          digit_d = digit_q - 4'd1;
        end
      end else begin
        if (digit_q == MAX) begin
          digit_d = 4'd0;
          dp_d    = 1'b1;
        end else begin
          digit_d = digit_q + 4'd1;
        end
      end
    end
  end

  always_comb begin
    seg = 7'h00;
    case (digit_q)
      4'd0: seg = 7'h3F;
      4'd1: seg = 7'h06;
      4'd2: seg = 7'h5B;
      4'd3: seg = 7'h4F;
      4'd4: seg = 7'h66;
      4'd5: seg = 7'h6D;
      4'd6: seg = 7'h7D;
      4'd7: seg = 7'h07;
      4'd8: seg = 7'h7F;
      4'd9: seg = 7'h6F;
`ifdef SEG7_SEQ_HEX_EN
      4'd10: seg = 7'h77;
      4'd11: seg = 7'h7C;
      4'd12: seg = 7'h39;
      4'd13: seg = 7'h5E;
      4'd14: seg = 7'h79;
      4'd15: seg = 7'h71;
`endif
      default: seg = 7'h00;
    endcase
  end

  assign io_out = {dp_q, seg};

endmodule

// File: tb/tb_seg7_digit_sequencer.sv
// Scoreboard bench for seg7_digit_sequencer: every change of io_out is an event checked for value and cycle.
// Expected values follow the hex encodings when SEG7_SEQ_HEX_EN is defined.
module tb_seg7_digit_sequencer;

  typedef struct {
    logic [7:0] val;
    int         cyc;
  } item_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       dir = 1'b0;
  logic       step = 1'b0;
  logic [2:0] sel = 3'd0;
  logic [7:0] ioIn;
  logic [7:0] ioOut;

  item_t      sbq[$];
  int         cyc = 0;
  int         checkCount = 0;
  int         passCount = 0;
  bit         monEn = 1'b0;
  logic [7:0] prevOut = 8'h00;

  assign ioIn = {sel, step, dir, run, rst, clk};

  seg7_digit_sequencer dut (
    .io_in (ioIn),
    .io_out(ioOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp,
                             input int actCyc, input int expCyc);
    checkCount++;
    if (act === exp && actCyc == expCyc) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got io_out=%02h at cycle %0d, expected %02h at cycle %0d",
               name, act, actCyc, exp, expCyc);
    end
  endtask

  task automatic expectEvent(input logic [7:0] val, input int atCyc);
    item_t it;
    it.val = val;
    it.cyc = atCyc;
    sbq.push_back(it);
  endtask

  // Monitor: any change on io_out must match the oldest pending expectation.
  always @(negedge clk) begin
    if (monEn && ioOut !== prevOut) begin
      if (sbq.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_event: got io_out=%02h at cycle %0d, expected no change",
                 ioOut, cyc);
      end else begin
        item_t it;
        it = sbq.pop_front();
        checkOutput("event", ioOut, it.val, cyc, it.cyc);
      end
      prevOut = ioOut;
    end
  end

  task automatic applyStimulus();
    int c;
    logic [7:0] stepVals [3];
    stepVals[0] = 8'h06;
    stepVals[1] = 8'h5B;
    stepVals[2] = 8'h4F;

    // Power-on reset, two cycles with run low
    repeat (2) @(negedge clk);
    checkOutput("reset_out", ioOut, 8'h3F, cyc, 2);
    rst = 1'b0;
    prevOut = ioOut;
    monEn = 1'b1;

    // Three 4-cycle step pulses counting up in IDLE
    for (int i = 0; i < 3; i++) begin
      c = cyc;
      expectEvent(stepVals[i], c + 4);
      step = 1'b1;
      repeat (4) @(negedge clk);
      step = 1'b0;
      repeat (4) @(negedge clk);
    end

    // Reset back to 0, then step down through the wrap
    c = cyc;
    rst = 1'b1;
    expectEvent(8'h3F, c + 1);
    @(negedge clk);
    rst = 1'b0;
    dir = 1'b1;
    step = 1'b1;
    c = cyc;
`ifdef SEG7_SEQ_HEX_EN
    expectEvent(8'hF1, c + 4);
    expectEvent(8'h71, c + 5);
`else
    expectEvent(8'hEF, c + 4);
    expectEvent(8'h6F, c + 5);
`endif
    repeat (4) @(negedge clk);
    step = 1'b0;
    repeat (6) @(negedge clk);

    // Run up at sel=0 for eight advances, then sel=3 while stepping (steps ignored)
    c = cyc;
    dir = 1'b0;
    run = 1'b1;
    sel = 3'd0;
    expectEvent(8'hBF, c + 4);
    expectEvent(8'h06, c + 5);
    expectEvent(8'h5B, c + 6);
    expectEvent(8'h4F, c + 7);
    expectEvent(8'h66, c + 8);
    expectEvent(8'h6D, c + 9);
    expectEvent(8'h7D, c + 10);
    expectEvent(8'h07, c + 11);
    expectEvent(8'h7F, c + 19);
    expectEvent(8'h6F, c + 27);
`ifdef SEG7_SEQ_HEX_EN
    expectEvent(8'h77, c + 35);
    expectEvent(8'h7C, c + 43);
`else
    expectEvent(8'hBF, c + 35);
    expectEvent(8'h3F, c + 36);
    expectEvent(8'h06, c + 43);
`endif
    repeat (11) @(negedge clk);
    sel = 3'd3;
    for (int i = 0; i < 4; i++) begin
      step = 1'b1;
      repeat (4) @(negedge clk);
      step = 1'b0;
      repeat (4) @(negedge clk);
    end

    // Stop mid-count: digit must stay frozen
    run = 1'b0;
    repeat (12) @(negedge clk);

    // Restart with sel=2: first advance four cycles after RUN entry
    c = cyc;
    sel = 3'd2;
    run = 1'b1;
`ifdef SEG7_SEQ_HEX_EN
    expectEvent(8'h39, c + 7);
    expectEvent(8'h5E, c + 11);
`else
    expectEvent(8'h5B, c + 7);
    expectEvent(8'h4F, c + 11);
`endif
    repeat (12) @(negedge clk);

    // Fast count at sel=0, then reset while running
    c = cyc;
    sel = 3'd0;
`ifdef SEG7_SEQ_HEX_EN
    expectEvent(8'h79, c + 1);
    expectEvent(8'h71, c + 2);
    expectEvent(8'hBF, c + 3);
`else
    expectEvent(8'h66, c + 1);
    expectEvent(8'h6D, c + 2);
    expectEvent(8'h7D, c + 3);
`endif
    expectEvent(8'h3F, c + 4);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_run", ioOut, 8'h3F, cyc, c + 4);
    rst = 1'b0;

    // A step after that reset proves the FSM returned to IDLE
    c = cyc;
    step = 1'b1;
    expectEvent(8'h06, c + 4);
    repeat (4) @(negedge clk);
    step = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    applyStimulus();
    checkCount++;
    if (sbq.size() == 0) begin
      passCount++;
    end else begin
      $display("[TB] FAIL pending_events: got %0d outstanding, expected 0", sbq.size());
    end
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
